// File: rtl/josh_pkg.sv
// Shared definitions for the frame sequencer slice: state encoding,
// screen geometry and colour constants.
package josh_pkg;

  typedef enum logic [3:0] {
    S_MENU,
    S_MENU_WAIT,
    S_LATCH,
    S_DRAW,
    S_WAIT_TICK,
    S_ERASE,
    S_UPDATE,
    S_CHECK,
    S_OVER
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  localparam logic [7:0] SCORE_MAX = 8'hFF;

  // States in which a game is in progress (drives startgame).
  function automatic logic is_running(input state_t s);
    return (s == S_LATCH) || (s == S_DRAW) || (s == S_CHECK) ||
           (s == S_WAIT_TICK) || (s == S_ERASE) || (s == S_UPDATE);
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Signal bundle between the frame sequencer and the game datapath / VGA
// adapter. master = sequencer side, slave = datapath/board side.
interface frame_sequencer_if;

  logic       go;
  logic       grav;
  logic       endgame;
  logic [7:0] dude_x;
  logic [6:0] dude_y;

  logic       startgame;
  logic       ld_pos;
  logic       grav_flip;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic [7:0] score;

  modport master (
    input  go, grav, endgame, dude_x, dude_y,
    output startgame, ld_pos, grav_flip, plot, x, y, colour, score
  );

  modport slave (
    output go, grav, endgame, dude_x, dude_y,
    input  startgame, ld_pos, grav_flip, plot, x, y, colour, score
  );

endinterface

// File: rtl/frame_sequencer_tick_gen.sv
// Frame tick generator: free-running divider that pulses tick for one
// cycle every TICK_DIV enabled cycles; held at zero while disabled.
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider count: wraps at TICK_DIV-1, parked at zero when idle or cleared.
  always_ff @(posedge clk) begin
    if (!resetn || clear || !enable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Game frame sequencer: menu handling, per-frame erase/update/draw of the
// player sprite, collision check, gravity-flip request latching and score.
module frame_sequencer
  import josh_pkg::*;
#(
  parameter int         TICK_DIV    = 833333,
  parameter int         DUDE_W      = 4,
  parameter int         DUDE_H      = 4,
  parameter int         SCREEN_W    = josh_pkg::SCREEN_W,
  parameter int         SCREEN_H    = josh_pkg::SCREEN_H,
  parameter logic [2:0] DUDE_COLOUR = COLOUR_WHITE
) (
  input  logic              clk,
  input  logic              resetn,
  frame_sequencer_if.master bus
);

  localparam logic [7:0] CX_LAST = 8'(DUDE_W - 1);
  localparam logic [6:0] CY_LAST = 7'(DUDE_H - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [7:0] score_q;
  logic       grav_pending;

  logic       tick;
  logic       tick_clr;
  logic       running;
  logic       sweep;
  logic       last_px;
  logic [8:0] px;
  logic [7:0] py;
  logic       on_screen;

  logic       plot_c;
  logic [7:0] x_c;
  logic [6:0] y_c;
  logic [2:0] colour_c;
  logic       ld_pos_c;
  logic       grav_flip_c;

  // Score increment that sticks at the maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == SCORE_MAX) ? s : s + 8'd1;
  endfunction

  assign running  = is_running(state);
  assign sweep    = (state == S_DRAW) || (state == S_ERASE);
  assign last_px  = (cx == CX_LAST) && (cy == CY_LAST);
  // Leaving the menu starts a fresh game: score and frame phase restart.
  assign tick_clr = (state == S_MENU_WAIT) && !bus.go;

  // Pixel address computed one bit wider so off-screen pixels do not wrap.
  assign px        = {1'b0, pos_x} + {1'b0, cx};
  assign py        = {1'b0, pos_y} + {1'b0, cy};
  assign on_screen = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .enable (running),
    .clear  (tick_clr),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_MENU;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_MENU:      if (bus.go) state_nxt = S_MENU_WAIT;
      S_MENU_WAIT: if (!bus.go) state_nxt = S_LATCH;
      S_LATCH:     state_nxt = S_DRAW;
      S_DRAW:      if (last_px) state_nxt = S_CHECK;
      S_CHECK:     state_nxt = bus.endgame ? S_OVER : S_WAIT_TICK;
      S_WAIT_TICK: if (tick) state_nxt = S_ERASE;
      S_ERASE:     if (last_px) state_nxt = S_UPDATE;
      S_UPDATE:    state_nxt = S_LATCH;
      S_OVER:      if (bus.go) state_nxt = S_MENU_WAIT;
      default:     state_nxt = S_MENU;
    endcase
  end

  // Output decode from registered state, sweep counters and latched position.
  always_comb begin
    plot_c      = 1'b0;
    x_c         = 8'd0;
    y_c         = 7'd0;
    colour_c    = COLOUR_BLACK;
    ld_pos_c    = 1'b0;
    grav_flip_c = 1'b0;
    case (state)
      S_DRAW: begin
        plot_c   = on_screen;
        x_c      = px[7:0];
        y_c      = py[6:0];
        colour_c = DUDE_COLOUR;
      end
      S_ERASE: begin
        plot_c   = on_screen;
        x_c      = px[7:0];
        y_c      = py[6:0];
        colour_c = COLOUR_BLACK;
      end
      S_UPDATE: begin
        ld_pos_c    = 1'b1;
        grav_flip_c = grav_pending | bus.grav;
      end
      default: begin
      end
    endcase
  end

  // Sprite sweep counters: cx inner, cy outer, back to origin after the last pixel.
  always_ff @(posedge clk) begin
    if (!resetn || !sweep) begin
      cx <= 8'd0;
      cy <= 7'd0;
    end else if (cx == CX_LAST) begin
      cx <= 8'd0;
      cy <= (cy == CY_LAST) ? 7'd0 : cy + 7'd1;
    end else begin
      cx <= cx + 8'd1;
    end
  end

  // Sprite origin captured once per frame so erase hits exactly what was drawn.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pos_x <= 8'd0;
      pos_y <= 7'd0;
    end else if (state == S_LATCH) begin
      pos_x <= bus.dude_x;
      pos_y <= bus.dude_y;
    end
  end

  // Score: cleared on game start, bumped on every surviving frame.
  always_ff @(posedge clk) begin
    if (!resetn || tick_clr) begin
      score_q <= 8'd0;
    end else if ((state == S_CHECK) && !bus.endgame) begin
      score_q <= sat_inc(score_q);
    end
  end

  // Gravity request memory: catches short presses between updates.
  always_ff @(posedge clk) begin
    if (!resetn || (state == S_UPDATE)) begin
      grav_pending <= 1'b0;
    end else if (running && bus.grav) begin
      grav_pending <= 1'b1;
    end
  end

  assign bus.startgame = running;
  assign bus.ld_pos    = ld_pos_c;
  assign bus.grav_flip = grav_flip_c;
  assign bus.plot      = plot_c;
  assign bus.x         = x_c;
  assign bus.y         = y_c;
  assign bus.colour    = colour_c;
  assign bus.score     = score_q;

endmodule
